// File: rtl/tick_divider_pkg.sv
// Shared constants and helpers for the tick_divider clock-enable generator.
package tick_divider_pkg;

    // Default counter / divisor width
    localparam int unsigned CNT_W_DEF    = 18;

    // Reset divisor: 2^17 gives a 763 Hz tick at 100 MHz
    localparam int unsigned DIV_INIT_DEF = 131072;

    // Divisor for a 4-digit display scan
    localparam int unsigned DISPLAY_DIV  = 65536;

    // Divisors of 0 and 1 both mean "tick every cycle"
    function automatic int unsigned eff_div(input int unsigned div);
        return (div < 2) ? 1 : div;
    endfunction

endpackage

// File: rtl/tick_div_ch.sv
// One tick_divider channel: counter, active divisor, pending divisor and registered tick.
// The square-wave flop exists only when SQUARE_OUT_EN is defined; otherwise sq is tied to 0.
module tick_div_ch
    import tick_divider_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned DIV_INIT = DIV_INIT_DEF
) (
    input  logic             clk_fast,
    input  logic             rst,
    input  logic             run,
    input  logic             sync_clr,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             sq
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] d_eff;
    logic [CNT_W-1:0] last;
    logic             wrap;
    logic             load;

    // Next-state: count, wrap, and pending-divisor hand-over
    always_comb begin
        d_eff      = CNT_W'(eff_div(32'(div_q)));
        last       = d_eff - CNT_W'(1);
        wrap       = run && (cnt_q == last);
        // A new divisor only takes effect where the count restarts from 0
        load       = pend_vld_q && (!run || sync_clr || wrap);

        cnt_d      = '0;
        tick_d     = 1'b0;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;

        if (run && !sync_clr) begin
            if (wrap) begin
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (load) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
        end

        // A write coinciding with a load lands in pend for the following wrap
        if (wr_en) begin
            pend_d     = wr_div;
            pend_vld_d = 1'b1;
        end
    end

    // Channel state registers
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            div_q      <= CNT_W'(DIV_INIT);
            pend_q     <= CNT_W'(DIV_INIT);
            pend_vld_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            tick_q     <= tick_d;
        end
    end

    assign tick = tick_q;

`ifdef SQUARE_OUT_EN
    logic sq_q;

    // Toggle alongside each tick; holds while the channel is idle
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_q ^ tick_d;
        end
    end

    assign sq = sq_q;
`else
    assign sq = 1'b0;
`endif

endmodule

// File: rtl/tick_divider.sv
// Multi-channel programmable clock-enable generator. Emits one-cycle tick pulses on clk_fast.
// Optional square-wave outputs are built when SQUARE_OUT_EN is defined.
module tick_divider
    import tick_divider_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned DIV_INIT = DIV_INIT_DEF,
    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_fast,
    input  logic             rst,
    input  logic [N_CH-1:0]  run,
    input  logic             sync_clr,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_div,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  sq_out
);

    logic            rst_meta_q;
    logic            rst_sync_q;
    logic [N_CH-1:0] wr_sel;

    // Reset synchroniser: asserts immediately, releases on one common edge for all channels
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= rst_meta_q;
        end
    end

    // Write decode; an out-of-range channel index selects nothing
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            wr_sel[i] = wr_en && (int'(wr_ch) == i);
        end
    end

    // One channel per run bit; sync_clr fans out to all of them
    for (genvar g = 0; g < int'(N_CH); g++) begin : gen_ch
        tick_div_ch #(
            .CNT_W    (CNT_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clk_fast (clk_fast),
            .rst      (rst_sync_q),
            .run      (run[g]),
            .sync_clr (sync_clr),
            .wr_en    (wr_sel[g]),
            .wr_div   (wr_div),
            .tick     (tick[g]),
            .sq       (sq_out[g])
        );
    end

endmodule

// File: tb/tb_tick_divider.sv
// Directed bench for tick_divider. Expected tick/sq vectors are pushed per cycle and popped
// after each clock edge. Square-wave expectations follow SQUARE_OUT_EN when it is defined.
module tb_tick_divider;

    logic        clk_fast = 1'b0;
    logic        rst;
    logic [3:0]  run;
    logic        sync_clr;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [17:0] wr_div;
    logic [3:0]  tick;
    logic [3:0]  sq_out;

    typedef struct {
        logic [3:0] tick;
        logic [3:0] sq;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] exp_sq;
    int         checks = 0;
    int         fails  = 0;

    tick_divider #(
        .N_CH     (4),
        .CNT_W    (18),
        .DIV_INIT (131072)
    ) dut (
        .clk_fast (clk_fast),
        .rst      (rst),
        .run      (run),
        .sync_clr (sync_clr),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_div   (wr_div),
        .tick     (tick),
        .sq_out   (sq_out)
    );

    always #5 clk_fast = ~clk_fast;

    task automatic check4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Square wave toggles on every expected tick
    task automatic push(input logic [3:0] t, input string tag);
        exp_t e;
`ifdef SQUARE_OUT_EN
        exp_sq = exp_sq ^ t;
`endif
        e.tick = t;
        e.sq   = exp_sq;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk_fast);
        #1;
        if (sb.size() == 0) begin
            checks++;
            fails++;
            $error("FAIL sb_empty: got no expectation, expected one queued");
        end else begin
            e = sb.pop_front();
            check4({e.tag, "_tick"}, tick, e.tick);
            check4({e.tag, "_sq"}, sq_out, e.sq);
        end
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            push(4'b0000, tag);
            step();
        end
    endtask

    // Steps k0..k0+n-1 after run rises; channel i ticks at f[i], f[i]+p[i], ... (p[i]=0: silent)
    task automatic play(input int k0, input int n, input int unsigned p[4],
                        input int unsigned f[4], input string tag);
        logic [3:0] t;
        for (int k = k0; k < k0 + n; k++) begin
            t = '0;
            for (int i = 0; i < 4; i++) begin
                if (p[i] != 0 && k >= int'(f[i]) && ((k - int'(f[i])) % int'(p[i])) == 0) begin
                    t[i] = 1'b1;
                end
            end
            push(t, tag);
            step();
        end
    endtask

    // Write while the channel is idle: latch, then applied on the next edge
    task automatic write_div(input logic [1:0] ch, input int unsigned d, input string tag);
        wr_en  = 1'b1;
        wr_ch  = ch;
        wr_div = 18'(d);
        push(4'b0000, tag);
        step();
        wr_en  = 1'b0;
        push(4'b0000, tag);
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        run      = 4'b0000;
        sync_clr = 1'b0;
        wr_en    = 1'b0;
        wr_ch    = 2'd0;
        wr_div   = '0;
        exp_sq   = 4'b0000;

        // 1: reset state, then long idle
        repeat (5) @(posedge clk_fast);
        #1;
        check4("t1_rst_tick", tick, 4'b0000);
        check4("t1_rst_sq", sq_out, 4'b0000);
        rst = 1'b0;
        idle(1000, "t1_idle");

        // 2: ch0 div=4, first tick 4 cycles after run
        write_div(2'd0, 4, "t2_wr");
        run = 4'b0001;
        play(1, 12, '{4, 0, 0, 0}, '{4, 0, 0, 0}, "t2_div4");
        run = 4'b0000;

        // 3: ch1 div=10, rewrite to 3 at cnt=3; current period completes first
        write_div(2'd1, 10, "t3_wr");
        run = 4'b0010;
        play(1, 3, '{0, 10, 0, 0}, '{0, 10, 0, 0}, "t3_p10");
        wr_en  = 1'b1;
        wr_ch  = 2'd1;
        wr_div = 18'd3;
        play(4, 1, '{0, 3, 0, 0}, '{0, 10, 0, 0}, "t3_wr_mid");
        wr_en  = 1'b0;
        play(5, 15, '{0, 3, 0, 0}, '{0, 10, 0, 0}, "t3_p3");
        run = 4'b0000;

        // 4: div=0 and div=1 both tick every cycle
        write_div(2'd2, 0, "t4_wr0");
        run = 4'b0100;
        play(1, 6, '{0, 0, 1, 0}, '{0, 0, 1, 0}, "t4_div0");
        run = 4'b0000;
        write_div(2'd2, 1, "t4_wr1");
        run = 4'b0100;
        play(1, 5, '{0, 0, 1, 0}, '{0, 0, 1, 0}, "t4_div1");
        run = 4'b0000;

        // 5: sync_clr coinciding with a ch0 wrap suppresses the tick and restarts both
        write_div(2'd0, 5, "t5_wr0");
        write_div(2'd1, 7, "t5_wr1");
        run = 4'b0011;
        play(1, 9, '{5, 7, 0, 0}, '{5, 7, 0, 0}, "t5_run");
        sync_clr = 1'b1;
        push(4'b0000, "t5_sync_wrap");
        step();
        sync_clr = 1'b0;
        play(11, 7, '{5, 7, 0, 0}, '{15, 17, 0, 0}, "t5_after_sync");

        // Reset right after a ch1 tick: outputs clear without a clock edge
        rst = 1'b1;
        #1;
        check4("t5_rst_async_tick", tick, 4'b0000);
        check4("t5_rst_async_sq", sq_out, 4'b0000);
        exp_sq = 4'b0000;
        run    = 4'b0000;
        idle(3, "t5_rst_hold");
        rst = 1'b0;
        idle(3, "t5_rst_rel");
        // Divisors are back to 2^17, so nothing ticks in a short window
        run = 4'b0011;
        idle(20, "t5_div_init");
        run = 4'b0000;

        // 6: ch3 div=6; square wave period 12 when enabled, else constant 0
        write_div(2'd3, 6, "t6_wr");
        run = 4'b1000;
        play(1, 30, '{0, 0, 0, 6}, '{0, 0, 0, 6}, "t6_sq");
        run = 4'b0000;
        idle(2, "t6_end");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
